// File: rtl/parity_error_logger_pkg.sv
// Shared types and default widths for the parity error logger slice.
package parity_error_logger_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_IDX_W  = 4;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic {
      ST_MONITOR = 1'b0,
      ST_ALARM   = 1'b1
   } alarm_state_t;

   typedef struct packed {
      logic [DEF_IDX_W-1:0]  idx;
      logic [DEF_DATA_W-1:0] data;
   } log_entry_t;

endpackage

// File: rtl/parity_error_logger_err_fifo.sv
// Show-ahead synchronous FIFO holding failing {idx, data} entries.
module parity_error_logger_err_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   // A pop frees a slot in the same edge, so a full FIFO can still take a push.
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!i_rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/parity_error_logger.sv
// Counts checked words and parity failures, logs failing words, raises a sticky alarm.
//   state      | meaning
//   ST_MONITOR | counting, err_count below THRESH so far
//   ST_ALARM   | err_count reached THRESH; held until reset/clear
module parity_error_logger
   import parity_error_logger_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int DEPTH  = 4,
   parameter int THRESH = 3,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic              parity_match,
   input  logic              clear,
   input  logic              log_rd,
   output logic              log_valid,
   output logic [IDX_W-1:0]  log_idx,
   output logic [DATA_W-1:0] log_data,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              alarm,
   output logic              overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(THRESH);

   alarm_state_t            r_state;
   alarm_state_t            w_state_nxt;
   logic [CNT_W-1:0]        r_word_count;
   logic [CNT_W-1:0]        r_err_count;
   logic                    r_overflow;
   logic                    w_accept;
   logic                    w_err;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop_eff;
   logic [IDX_W+DATA_W-1:0] w_head;

   // Clear overrides any concurrent input that cycle.
   assign w_accept  = in_valid && !clear;
   assign w_err     = w_accept && !parity_match;
   assign w_pop_eff = log_rd && !w_empty && !clear;

   parity_error_logger_err_fifo #(
      .WIDTH (IDX_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_err_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_flush (clear),
      .i_push  (w_err),
      .i_wdata ({in_idx, in_data}),
      .i_pop   (log_rd),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_word_count <= '0;
         r_err_count  <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_accept && r_word_count != CNT_MAX) begin
            r_word_count <= r_word_count + 1'b1;
         end
         if (w_err && r_err_count != CNT_MAX) begin
            r_err_count <= r_err_count + 1'b1;
         end
         if (w_err && w_full && !w_pop_eff) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_state <= ST_MONITOR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_MONITOR: if (r_err_count >= THRESH_CNT) w_state_nxt = ST_ALARM;
         ST_ALARM:   w_state_nxt = ST_ALARM;
         default:    w_state_nxt = ST_MONITOR;
      endcase
   end

   assign log_valid  = !w_empty;
   assign log_idx    = w_head[IDX_W+DATA_W-1:DATA_W];
   assign log_data   = w_head[DATA_W-1:0];
   assign word_count = r_word_count;
   assign err_count  = r_err_count;
   assign alarm      = (r_state == ST_ALARM);
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_parity_error_logger.sv
// Directed self-checking bench for parity_error_logger (default parameters).
module tb_parity_error_logger;
   import parity_error_logger_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] in_idx;
   logic       parity_match;
   logic       clear;
   logic       log_rd;
   logic       log_valid;
   logic [3:0] log_idx;
   logic [7:0] log_data;
   logic [7:0] word_count;
   logic [7:0] err_count;
   logic       alarm;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   parity_error_logger #(
      .DATA_W (8), .IDX_W (4), .DEPTH (4), .THRESH (3), .CNT_W (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_idx       (in_idx),
      .parity_match (parity_match),
      .clear        (clear),
      .log_rd       (log_rd),
      .log_valid    (log_valid),
      .log_idx      (log_idx),
      .log_data     (log_data),
      .word_count   (word_count),
      .err_count    (err_count),
      .alarm        (alarm),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] idx, input logic [7:0] d,
                        input logic pm, input logic rd);
      in_valid = v; in_idx = idx; in_data = d; parity_match = pm; log_rd = rd;
      cycle();
      in_valid = 1'b0; log_rd = 1'b0; parity_match = 1'b1;
   endtask

   task automatic do_reset();
      in_valid = 0; in_idx = 0; in_data = 0; parity_match = 1; clear = 0; log_rd = 0;
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 0; in_idx = 0; in_data = 0; parity_match = 1; clear = 0; log_rd = 0;
      reset = 1'b0;
      cycle(); cycle();
      reset = 1'b1;
      cycle();
      total++;
      if ({log_valid, log_idx, log_data} !== 13'h0) begin
         bad++; $display("FAIL reset_log got=%0h exp=0", {log_valid, log_idx, log_data});
      end
      total++;
      if ({word_count, err_count} !== 16'h0) begin
         bad++; $display("FAIL reset_counts got=%0h exp=0", {word_count, err_count});
      end
      total++;
      if ({alarm, overflow} !== 2'b00) begin
         bad++; $display("FAIL reset_flags got=%0b exp=00", {alarm, overflow});
      end
   endtask

   task automatic test_good_words();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1; in_idx = 4'(i); in_data = 8'(i * 7); parity_match = 1;
         cycle();
      end
      in_valid = 0;
      cycle();
      total++;
      if (word_count !== 8'd16) begin
         bad++; $display("FAIL good_word_count got=%0d exp=16", word_count);
      end
      total++;
      if ({err_count, log_valid, alarm, overflow} !== 11'h0) begin
         bad++; $display("FAIL good_no_err got=%0h exp=0", {err_count, log_valid, alarm, overflow});
      end
   endtask

   task automatic test_fifo_basic();
      do_reset();
      drive(1, 4'd3, 8'hD9, 0, 0);
      total++;
      if ({log_valid, log_idx, log_data} !== {1'b1, 4'd3, 8'hD9}) begin
         bad++; $display("FAIL first_err_head got=%0h exp=13d9", {log_valid, log_idx, log_data});
      end
      drive(1, 4'd4, 8'h11, 1, 0);
      drive(1, 4'd9, 8'hAA, 0, 0);
      total++;
      if ({word_count, err_count} !== {8'd3, 8'd2}) begin
         bad++; $display("FAIL basic_counts got=%0h exp=0302", {word_count, err_count});
      end
      total++;
      if ({log_idx, log_data} !== {4'd3, 8'hD9}) begin
         bad++; $display("FAIL head_stable got=%0h exp=3d9", {log_idx, log_data});
      end
      drive(0, 0, 0, 1, 1);
      total++;
      if ({log_valid, log_idx, log_data} !== {1'b1, 4'd9, 8'hAA}) begin
         bad++; $display("FAIL pop1_head got=%0h exp=19aa", {log_valid, log_idx, log_data});
      end
      drive(0, 0, 0, 1, 1);
      total++;
      if ({log_valid, log_idx, log_data} !== 13'h0) begin
         bad++; $display("FAIL pop2_empty got=%0h exp=0", {log_valid, log_idx, log_data});
      end
      drive(0, 0, 0, 1, 1);
      total++;
      if ({log_valid, err_count, overflow} !== {1'b0, 8'd2, 1'b0}) begin
         bad++; $display("FAIL pop_empty_ignored got=%0h exp=004", {log_valid, err_count, overflow});
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 4'(i), 8'(8'h10 + i), 0, 0);
         total++;
         if (alarm !== (i >= 3)) begin
            bad++; $display("FAIL alarm_timing_%0d got=%0b exp=%0b", i, alarm, (i >= 3));
         end
         total++;
         if (overflow !== (i == 4)) begin
            bad++; $display("FAIL overflow_timing_%0d got=%0b exp=%0b", i, overflow, (i == 4));
         end
      end
      total++;
      if (err_count !== 8'd5) begin
         bad++; $display("FAIL ovf_err_count got=%0d exp=5", err_count);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({log_valid, log_idx, log_data} !== {1'b1, 4'(i), 8'(8'h10 + i)}) begin
            bad++; $display("FAIL ovf_drain_%0d got=%0h exp=%0h", i,
                            {log_valid, log_idx, log_data}, {1'b1, 4'(i), 8'(8'h10 + i)});
         end
         drive(0, 0, 0, 1, 1);
      end
      total++;
      if (log_valid !== 1'b0) begin
         bad++; $display("FAIL ovf_drained got=%0b exp=0", log_valid);
      end
   endtask

   task automatic test_full_pop();
      log_entry_t exp_q [4];
      exp_q[0] = '{idx: 4'd1, data: 8'h21};
      exp_q[1] = '{idx: 4'd2, data: 8'h22};
      exp_q[2] = '{idx: 4'd3, data: 8'h23};
      exp_q[3] = '{idx: 4'd7, data: 8'h77};
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, 4'(i), 8'(8'h20 + i), 0, 0);
      drive(1, 4'd7, 8'h77, 0, 1);
      total++;
      if ({overflow, err_count} !== {1'b0, 8'd5}) begin
         bad++; $display("FAIL full_pop_no_ovf got=%0h exp=005", {overflow, err_count});
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({log_valid, log_idx, log_data} !== {1'b1, exp_q[i]}) begin
            bad++; $display("FAIL full_pop_entry_%0d got=%0h exp=%0h", i,
                            {log_valid, log_idx, log_data}, {1'b1, exp_q[i]});
         end
         drive(0, 0, 0, 1, 1);
      end
      total++;
      if (log_valid !== 1'b0) begin
         bad++; $display("FAIL full_pop_occupancy got=%0b exp=0", log_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, 4'd5, 8'h5C, 0, 1);
      total++;
      if ({log_valid, log_idx, log_data} !== {1'b1, 4'd5, 8'h5C}) begin
         bad++; $display("FAIL empty_push_pop got=%0h exp=155c", {log_valid, log_idx, log_data});
      end
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 4'(i + 8), 8'(8'hC0 + i), 0, 0);
      cycle();
      total++;
      if ({alarm, overflow, log_valid} !== 3'b111) begin
         bad++; $display("FAIL pre_clear_flags got=%0b exp=111", {alarm, overflow, log_valid});
      end
      clear = 1; in_valid = 1; parity_match = 0; in_idx = 4'hF; in_data = 8'hFF; log_rd = 1;
      cycle();
      clear = 0; in_valid = 0; parity_match = 1; log_rd = 0;
      total++;
      if ({word_count, err_count, alarm, overflow, log_valid, log_idx, log_data} !== 31'h0) begin
         bad++; $display("FAIL clear_all got=%0h exp=0",
                         {word_count, err_count, alarm, overflow, log_valid, log_idx, log_data});
      end
      cycle();
      total++;
      if (alarm !== 1'b0) begin
         bad++; $display("FAIL clear_alarm_held got=%0b exp=0", alarm);
      end
      drive(1, 4'd2, 8'h42, 0, 0);
      reset = 0; clear = 1;
      cycle();
      reset = 1; clear = 0;
      total++;
      if ({log_valid, word_count, err_count} !== 17'h0) begin
         bad++; $display("FAIL reset_midop got=%0h exp=0", {log_valid, word_count, err_count});
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 260; i++) begin
         in_valid = 1; in_idx = 4'(i); in_data = 8'(i); parity_match = 1;
         cycle();
      end
      in_valid = 0;
      total++;
      if ({word_count, err_count} !== {8'd255, 8'd0}) begin
         bad++; $display("FAIL word_saturate got=%0h exp=ff00", {word_count, err_count});
      end
      for (int i = 0; i < 260; i++) begin
         in_valid = 1; in_idx = 4'(i); in_data = 8'(i); parity_match = 0;
         cycle();
      end
      in_valid = 0; parity_match = 1;
      total++;
      if ({word_count, err_count, overflow} !== {8'd255, 8'd255, 1'b1}) begin
         bad++; $display("FAIL err_saturate got=%0h exp=1ffff", {word_count, err_count, overflow});
      end
   endtask

   initial begin
      test_reset();
      test_good_words();
      test_fifo_basic();
      test_overflow();
      test_full_pop();
      test_back_to_back();
      test_clear();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parity_error_logger.md
# parity_error_logger

Downstream consumer of the fetch/parity-check stage: samples each fetched word together with its 4-bit fetch index and parity-match flag, counts checked words and parity failures, and buffers each failing word with its index in a small show-ahead FIFO for a host to drain. An error count at or above a threshold raises a sticky alarm. Sits between the parity checker and the test/host logic.

## Interface
- DATA_W, 8, width of fetched data word
- IDX_W, 4, width of fetch index (counter value driving the 16:1 fetch mux)
- DEPTH, 4, error FIFO entries (power of two, ≥2)
- THRESH, 3, error count at which alarm asserts (1..255)
- CNT_W, 8, width of word and error counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  qualifies in_data/in_idx/parity_match this cycle
- in_data  in  DATA_W  fetched word
- in_idx  in  IDX_W  fetch index of in_data
- parity_match  in  1  1 = parity good, 0 = parity error
- clear  in  1  synchronous soft clear (same effect as reset)
- log_rd  in  1  pop head of error FIFO
- log_valid  out  1  FIFO non-empty; head fields valid
- log_idx  out  IDX_W  index of head entry
- log_data  out  DATA_W  data of head entry
- word_count  out  CNT_W  saturating count of accepted words
- err_count  out  CNT_W  saturating count of parity errors
- alarm  out  1  sticky, err_count ≥ THRESH
- overflow  out  1  sticky, an error arrived while FIFO full (entry dropped)

## Operation
- Accept: in_valid=1 at a rising edge. word_count += 1 (saturate at 2^CNT_W−1).
- Error: accept with parity_match=0 → err_count += 1 (saturate); push {in_idx, in_data} to FIFO.
- FIFO show-ahead: log_valid = not empty; log_idx/log_data = head entry, stable while log_valid and no pop; 0 when empty.
- Pop: log_rd=1 and log_valid=1 → head removed at edge. log_rd when empty ignored.
- Full + push, no pop: entry dropped, overflow←1, err_count still increments.
- Full + push + pop same cycle: both happen; no overflow; occupancy unchanged.
- Empty + push + pop same cycle: pop ignored, push accepted.
- Alarm FSM: MONITOR → ALARM when the registered err_count ≥ THRESH; ALARM held until reset/clear. alarm = (state==ALARM).
- clear=1 (with reset high): next edge all state returns to reset values, FIFO flushed; concurrent in_valid/log_rd that cycle ignored.
- reset has priority over clear; reset mid-operation discards in-flight FIFO contents.

## Timing
- Reset values: log_valid 0, log_idx 0, log_data 0, word_count 0, err_count 0, alarm 0, overflow 0, FSM MONITOR, FIFO empty.
- Counters and FIFO update at the edge sampling the input; new values visible the following cycle (1-cycle latency).
- Error written into empty FIFO: log_valid=1 one cycle after the sampling edge.
- alarm asserts one cycle after err_count first reads ≥ THRESH (2 cycles after the sampling edge of the THRESH-th error).
- overflow visible one cycle after the dropping edge.
- No combinational path from any input to any output.
- Accepts one word per cycle continuously.

## Structure
- Shared package: alarm FSM state typedef (MONITOR, ALARM), default DATA_W/IDX_W/CNT_W constants, FIFO entry struct {idx, data}.
- One sub-module: err_fifo (parameterised show-ahead sync FIFO, width IDX_W+DATA_W, depth DEPTH, push/pop/full/empty, same clk/reset, flush input for clear).
- Top holds counters, saturation logic, alarm FSM, overflow flag.

## Test plan
- Reset low 2 cycles then high, no stimulus → all outputs 0, log_valid 0.
- 16 back-to-back valid words idx 0..15, all parity_match=1 → word_count=16, err_count=0, log_valid=0, alarm=0.
- Errors at idx 3 (0xD9) and idx 9 (0xAA), log_rd=0 → err_count=2, FIFO head idx 3/0xD9; one pop → head idx 9/0xAA; second pop → log_valid=0.
- 5 consecutive errors with DEPTH=4, no pops → err_count=5, overflow=1, FIFO holds first 4 idx, alarm=1 two cycles after the 3rd error.
- FIFO full, error push with simultaneous log_rd → overflow stays 0, occupancy stays 4, new entry at tail.
- clear pulse while alarm=1 and FIFO non-empty → next cycle all counts 0, alarm 0, overflow 0, log_valid 0; in_valid that cycle not counted.
